// File: rtl/mem_program_loader_if.sv
// Byte-stream input and memory write-port bundle for the program loader.
// The stream side uses valid/ready; the write port is a plain registered strobe.
interface mem_program_loader_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_en;

  // Handshake: a byte moves on a rising clk edge where in_valid && in_ready;
  // the producer holds in_data stable while in_valid is high and not yet taken.
  modport master (
    input  in_data, in_valid,
    output in_ready, w_addr, w_data, w_en
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, w_addr, w_data, w_en
  );
endinterface

// File: rtl/mem_program_loader.sv
// Framed byte-stream loader: parses sync/addr/count/data/checksum frames and
// writes big-endian 16-bit words into consecutive memory addresses.
module mem_program_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int N_ELEMENTS = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_program_loader_if.master  bus,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] words_written,
  output logic [3:0]            state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO,
    S_DATA_HI, S_DATA_LO, S_WRITE, S_CHK
  } state_t;

  state_t state, state_next;

  logic [7:0]            addr_hi_q;
  logic [15:0]           start_addr;
  logic [7:0]            cnt_hi_q;
  logic [15:0]           cnt;
  logic [15:0]           idx;
  logic [7:0]            data_hi_q;
  logic [7:0]            acc;
  logic                  range_flag;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  in_range;
  logic                  more_words;

  assign bus.in_ready = !rst && (state != S_WRITE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign state_dbg    = state;

  // Address wraps at 2^ADDR_WIDTH; range check is done on the wrapped value.
  assign cur_addr   = ADDR_WIDTH'(start_addr) + ADDR_WIDTH'(idx);
  assign in_range   = 32'(cur_addr) < 32'(N_ELEMENTS);
  assign more_words = ({1'b0, idx} + 17'd1) < {1'b0, cnt};

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (accept && bus.in_data == 8'hA5) state_next = S_ADDR_HI;
      S_ADDR_HI: if (accept) state_next = S_ADDR_LO;
      S_ADDR_LO: if (accept) state_next = S_CNT_HI;
      S_CNT_HI:  if (accept) state_next = S_CNT_LO;
      S_CNT_LO:  if (accept) state_next = ({cnt_hi_q, bus.in_data} != 16'd0) ? S_DATA_HI : S_CHK;
      S_DATA_HI: if (accept) state_next = S_DATA_LO;
      S_DATA_LO: if (accept) state_next = S_WRITE;
      S_WRITE:   state_next = more_words ? S_DATA_HI : S_CHK;
      S_CHK:     if (accept) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      addr_hi_q     <= '0;
      start_addr    <= '0;
      cnt_hi_q      <= '0;
      cnt           <= '0;
      idx           <= '0;
      data_hi_q     <= '0;
      acc           <= '0;
      range_flag    <= 1'b0;
      bus.w_addr    <= '0;
      bus.w_data    <= '0;
      bus.w_en      <= 1'b0;
      cpu_hold      <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      words_written <= '0;
    end else begin
      state    <= state_next;
      bus.w_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && bus.in_data == 8'hA5) begin
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            words_written <= '0;
            acc           <= '0;
            range_flag    <= 1'b0;
            idx           <= '0;
          end
        end
        S_ADDR_HI: if (accept) addr_hi_q  <= bus.in_data;
        S_ADDR_LO: if (accept) start_addr <= {addr_hi_q, bus.in_data};
        S_CNT_HI:  if (accept) cnt_hi_q   <= bus.in_data;
        S_CNT_LO:  if (accept) cnt        <= {cnt_hi_q, bus.in_data};
        S_DATA_HI: begin
          if (accept) begin
            data_hi_q <= bus.in_data;
            acc       <= acc ^ bus.in_data;
          end
        end
        S_DATA_LO: begin
          // Write strobe is registered here so it lands in the WRITE cycle.
          if (accept) begin
            acc <= acc ^ bus.in_data;
            if (in_range) begin
              bus.w_en      <= 1'b1;
              bus.w_addr    <= cur_addr;
              bus.w_data    <= DATA_WIDTH'({data_hi_q, bus.in_data});
              words_written <= words_written + ADDR_WIDTH'(1);
            end else begin
              range_flag <= 1'b1;
            end
          end
        end
        S_WRITE: idx <= idx + 16'd1;
        S_CHK: begin
          if (accept) begin
            cpu_hold <= 1'b0;
            if (bus.in_data == acc && !range_flag) done <= 1'b1;
            else                                   err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_program_loader.sv
// Self-checking bench for mem_program_loader: table frames, corner sequences
// and random frames checked against a frame-level reference model.
module tb_mem_program_loader;

  logic        clk;
  logic        rst;
  logic        cpu_hold, done, err;
  logic [15:0] words_written;
  logic [3:0]  state_dbg;

  mem_program_loader_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

  mem_program_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .N_ELEMENTS(128)) dut (
    .clk(clk), .rst(rst), .bus(bus.master),
    .cpu_hold(cpu_hold), .done(done), .err(err),
    .words_written(words_written), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];   // {addr, data} of expected w_en pulses
  bit          wen_q[$];   // per word: write expected (address in range)
  logic [7:0]  frame_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.w_en) begin
      if (exp_q.size() == 0) fail_now("unexpected_w_en");
      else check("write_addr_data", {bus.w_addr, bus.w_data}, exp_q.pop_front());
    end
  end

  // ---------------- reference model ----------------
  // Parses frame_q from the sync byte at position pre; pushes expected writes.
  task automatic model(input int pre, output bit m_done, output bit m_err, output int m_ww);
    int start, cnt, addr;
    logic [7:0] acc, hi, lo, chk;
    bit rng;
    start = {frame_q[pre+1], frame_q[pre+2]};
    cnt   = {frame_q[pre+3], frame_q[pre+4]};
    acc = 8'h00; rng = 0; m_ww = 0;
    for (int k = 0; k < cnt; k++) begin
      addr = (start + k) % 65536;
      hi = frame_q[pre+5+2*k];
      lo = frame_q[pre+6+2*k];
      acc = acc ^ hi ^ lo;
      if (addr < 128) begin
        exp_q.push_back({addr[15:0], hi, lo});
        wen_q.push_back(1'b1);
        m_ww++;
      end else begin
        wen_q.push_back(1'b0);
        rng = 1;
      end
    end
    chk    = frame_q[pre+5+2*cnt];
    m_done = (chk == acc) && !rng;
    m_err  = !m_done;
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit lo, input bit lo_wen);
    int n;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      fail_now("in_ready_wait");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (lo) begin
      check("write_cycle_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("write_cycle_w_en", {31'd0, bus.w_en}, {31'd0, lo_wen});
    end
  endtask

  task automatic run_frame(input int pre, input bit gaps, input bit e_done, input bit e_err, input int e_ww);
    int cnt, idx;
    bit lo, lw;
    cnt = {frame_q[pre+3], frame_q[pre+4]};
    for (int i = 0; i < frame_q.size(); i++) begin
      idx = i - pre - 5;
      lo  = (idx >= 0) && (idx < 2*cnt) && (idx % 2 == 1);
      lw  = lo ? wen_q.pop_front() : 1'b0;
      send_byte(frame_q[i], gaps, lo, lw);
      if (i == pre - 1) check("hold_before_sync", {31'd0, cpu_hold}, 32'd0);
      if (i == pre) begin
        check("hold_after_sync", {31'd0, cpu_hold}, 32'd1);
        check("done_cleared_by_sync", {31'd0, done}, 32'd0);
        check("err_cleared_by_sync", {31'd0, err}, 32'd0);
      end
    end
    check("frame_done", {31'd0, done}, {31'd0, e_done});
    check("frame_err", {31'd0, err}, {31'd0, e_err});
    check("frame_hold_released", {31'd0, cpu_hold}, 32'd0);
    check("frame_words_written", {16'd0, words_written}, 32'(e_ww));
    check("frame_writes_all_seen", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load_frame(input logic [111:0] bytes, input int len);
    frame_q.delete();
    for (int i = 0; i < len; i++) frame_q.push_back(bytes[8*(len-1-i) +: 8]);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [111:0] bytes;   // right-aligned, first byte most significant
    int           len;
    int           pre;
    bit           exp_done;
    bit           exp_err;
    int           exp_ww;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit   m_done, m_err;
    int   m_ww, pre, start, cnt;
    logic [7:0] acc, b;

    vecs[0] = '{112'h A5_0010_0002_1234_ABCD_40,      10, 0, 1'b1, 1'b0, 2};
    vecs[1] = '{112'h A5_0010_0002_1234_ABCD_41,      10, 0, 1'b0, 1'b1, 2};
    vecs[2] = '{112'h 00FF3C_A5_0010_0002_1234_ABCD_40, 13, 3, 1'b1, 1'b0, 2};
    vecs[3] = '{112'h A5_007F_0002_1111_2222_00,      10, 0, 1'b0, 1'b1, 1};

    rst = 1'b1;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_w_en", {31'd0, bus.w_en}, 32'd0);
    check("rst_w_addr_data", {bus.w_addr, bus.w_data}, 32'd0);
    check("rst_status", {28'd0, cpu_hold, done, err, 1'b0}, 32'd0);
    check("rst_words_written", {16'd0, words_written}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Table frames
    foreach (vecs[v]) begin
      load_frame(vecs[v].bytes, vecs[v].len);
      model(vecs[v].pre, m_done, m_err, m_ww);
      run_frame(vecs[v].pre, 1'b0, vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_ww);
    end

    // Empty frame twice: second sync must clear done before it is set again
    for (int r = 0; r < 2; r++) begin
      load_frame(112'h A5_0000_0000_00, 6);
      model(0, m_done, m_err, m_ww);
      run_frame(0, 1'b0, 1'b1, 1'b0, 0);
    end

    // Reset after the first word of a three-word frame has been written
    exp_q.push_back({16'h0010, 16'h1234});
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0, 1'b0);
    send_byte(8'h10, 1'b0, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 1'b0, 1'b0);
    send_byte(8'h34, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("midrst_w_en", {31'd0, bus.w_en}, 32'd0);
    check("midrst_w_addr_data", {bus.w_addr, bus.w_data}, 32'd0);
    check("midrst_status", {29'd0, cpu_hold, done, err}, 32'd0);
    check("midrst_words_written", {16'd0, words_written}, 32'd0);
    check("midrst_first_write_seen", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    load_frame(vecs[0].bytes, vecs[0].len);
    model(0, m_done, m_err, m_ww);
    run_frame(0, 1'b1, 1'b1, 1'b0, 2);

    // Random frames against the model, one forced to wrap past 0xFFFF
    for (int f = 0; f < 20; f++) begin
      frame_q.delete();
      pre = $urandom_range(0, 2);
      for (int i = 0; i < pre; i++) frame_q.push_back(8'($urandom_range(0, 8'hA4)));
      start = (f == 0) ? 16'hFFFF : $urandom_range(0, 140);
      cnt   = $urandom_range(0, 5);
      frame_q.push_back(8'hA5);
      frame_q.push_back(8'(start >> 8));
      frame_q.push_back(8'(start));
      frame_q.push_back(8'(cnt >> 8));
      frame_q.push_back(8'(cnt));
      acc = 8'h00;
      for (int k = 0; k < 2*cnt; k++) begin
        b = 8'($urandom_range(0, 255));
        acc = acc ^ b;
        frame_q.push_back(b);
      end
      if ($urandom_range(0, 3) == 0) acc = acc ^ 8'($urandom_range(1, 255));
      frame_q.push_back(acc);
      model(pre, m_done, m_err, m_ww);
      run_frame(pre, 1'b1, m_done, m_err, m_ww);
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_program_loader.md
Name: mem_program_loader

Overview:
- Upstream feeder for the 2-read/1-write PUNC memory: drives its write port (w_addr, w_data, w_en) directly.
- Accepts a framed byte stream (from UART/host bridge) over valid/ready and assembles 16-bit words big-endian.
- Writes the words to consecutive memory addresses.
- Holds the CPU via cpu_hold while a frame is in progress, then reports done or err.

Parameters:
- ADDR_WIDTH, 16, memory address width; matches the memory's ADDR_WIDTH.
- DATA_WIDTH, 16, memory word width; only 16 is supported (two bytes per word).
- N_ELEMENTS, 128, number of memory words; addresses >= N_ELEMENTS are out of range.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte; transfer occurs when in_valid && in_ready at posedge
- w_addr  out  ADDR_WIDTH  memory write address
- w_data  out  DATA_WIDTH  memory write data
- w_en  out  1  memory write enable, single-cycle pulse
- cpu_hold  out  1  high while a frame is in progress
- done  out  1  last frame completed with good checksum and no range error
- err  out  1  last frame had a checksum mismatch or an out-of-range address
- words_written  out  ADDR_WIDTH  count of w_en pulses issued in the current/last frame

Behaviour:
- Frame format, in byte order:
  - 0xA5 sync
  - ADDR_HI, ADDR_LO (start address)
  - CNT_HI, CNT_LO (word count)
  - CNT words, each sent as DATA_HI then DATA_LO
  - CHK = XOR of all data bytes only (CNT=0 -> expected 0x00)
- States: IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CHK. All transitions below occur only on an accepted byte, except WRITE.
- IDLE:
  - Non-0xA5 bytes are consumed and discarded; no other effect.
  - Accepting 0xA5 -> ADDR_HI. On that edge: cpu_hold<=1, done<=0, err<=0, words_written<=0, checksum accumulator<=0, range flag<=0.
- ADDR_HI -> ADDR_LO -> CNT_HI -> CNT_LO: latch the corresponding bytes.
- After CNT_LO: -> DATA_HI if CNT != 0, else -> CHK.
- DATA_HI -> DATA_LO. Each data byte is XORed into the accumulator.
- DATA_LO accepted -> WRITE. WRITE lasts exactly one cycle:
  - in_ready=0.
  - w_en=1 with w_addr=start+index and w_data={hi,lo}, all registered.
  - The write occurs the cycle after the DATA_LO byte is accepted.
  - index increments.
  - Next state: DATA_HI if index+1 < CNT, else CHK.
- Address arithmetic: start+index modulo 2^ADDR_WIDTH (wraps).
- Out-of-range address (>= N_ELEMENTS):
  - w_en stays 0 in that WRITE cycle; range flag set (sticky for the frame).
  - words_written does not increment; the frame continues.
- CHK accepted:
  - Next cycle: cpu_hold<=0.
  - done<=1 iff CHK == accumulator and range flag clear; else err<=1.
  - -> IDLE.
- done/err hold until the next sync byte is accepted or rst.
- in_ready = 1 in every state except WRITE; in_ready = 0 during rst.
- w_en = 0 outside WRITE; w_addr/w_data hold their last values.
- Reset values: in_ready 0 during rst, 1 after; w_en 0; w_addr 0; w_data 0; cpu_hold 0; done 0; err 0; words_written 0; state IDLE.
- rst mid-frame: abort immediately to reset values. Words already written stay in memory (not undone), and no status is reported for the aborted frame.
- Gaps in in_valid are allowed in any state; the FSM waits without timeout.
- A 0xA5 byte seen outside IDLE is treated as data, not as a resync.

Test Plan:
- Good frame: A5 00 10 00 02 12 34 AB CD 40 -> w_en pulses at (0x0010, 0x1234) and (0x0011, 0xABCD), each one cycle after its lo byte. Then done=1, err=0, words_written=2, cpu_hold 1->0.
- Bad checksum: same frame with CHK=41 -> both writes still occur; err=1, done=0.
- Noise before sync: 00 FF 3C then the good frame -> noise ignored, cpu_hold stays 0 until A5 is accepted, result identical to the good-frame case.
- Range error (N_ELEMENTS=128): A5 00 7F 00 02 11 11 22 22 00 -> one write (0x007F, 0x1111); second write suppressed; words_written=1, err=1.
- Empty frame: A5 00 00 00 00 00 -> no w_en, done=1 the cycle after CHK; a second A5 clears done to 0.
- Reset mid-frame: assert rst after the first word is written -> all outputs return to reset values. A following good frame with random in_valid gaps still completes with done=1. in_ready=0 in every WRITE cycle.
